// File: rtl/pool_window_fetch.sv
// pool_window_fetch: walks a square conv map in 2x2 windows for a max-pooler.
// For each window it reads four samples from the conv RAM (1-cycle read latency),
// presents them stable with win_valid, waits for the pooler's result pulse and
// writes that result to the next pool-RAM address. One start = one full-map pass.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start / busy / done      pass control and status (done is a one-cycle pulse)
//   raddr, ren, rdata        conv RAM read port (rdata valid one cycle after ren)
//   rdata_conv0..3, win_valid  window TL, TR, BL, BR and its valid flag
//   save_rstl, max           pooler result strobe and value
//   waddr_pool, wdata_pool, we_pool  pool RAM write port
//   err                      watchdog flag, only with POOL_FETCH_TIMEOUT_EN
//
// Optional feature: define POOL_FETCH_TIMEOUT_EN to add a 255-cycle WAIT
// watchdog that aborts the pass to DONE and raises err.
module pool_window_fetch #(
    parameter int unsigned addressWidthConv = 10,
    parameter int unsigned dataWidthMax     = 8,
    parameter int unsigned IMG_W            = 26
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [addressWidthConv-1:0] raddr,
    output logic                        ren,
    input  logic [dataWidthMax-1:0]     rdata,
    output logic [dataWidthMax-1:0]     rdata_conv0,
    output logic [dataWidthMax-1:0]     rdata_conv1,
    output logic [dataWidthMax-1:0]     rdata_conv2,
    output logic [dataWidthMax-1:0]     rdata_conv3,
    output logic                        win_valid,
    input  logic                        save_rstl,
    input  logic [dataWidthMax-1:0]     max,
    output logic [addressWidthConv-1:0] waddr_pool,
    output logic [dataWidthMax-1:0]     wdata_pool,
`ifdef POOL_FETCH_TIMEOUT_EN
    output logic                        err,
`endif
    output logic                        we_pool
);

    localparam int unsigned AW = addressWidthConv;
    localparam int unsigned DW = dataWidthMax;
    localparam int unsigned KW = 3;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE} state_t;

    state_t          state, state_d;
    logic [KW-1:0]   k, k_d;
    logic [AW-1:0]   r, r_d, c, c_d, p, p_d;
    logic [AW-1:0]   r_inc, c_inc, base;
    logic [DW-1:0]   conv_q [4];
    logic [DW-1:0]   conv_d [4];
    logic [DW-1:0]   wdata_d;
    logic [AW-1:0]   raddr_d, waddr_d;
    logic            ren_d, busy_d, win_valid_d, we_d, done_d;
`ifdef POOL_FETCH_TIMEOUT_EN
    logic [7:0]      wd, wd_d;
    logic            err_d;
`endif

    assign rdata_conv0 = conv_q[0];
    assign rdata_conv1 = conv_q[1];
    assign rdata_conv2 = conv_q[2];
    assign rdata_conv3 = conv_q[3];

    assign r_inc = r + AW'(2);
    assign c_inc = c + AW'(2);

    // State register plus all counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            r          <= '0;
            c          <= '0;
            p          <= '0;
            conv_q     <= '{default: '0};
            wdata_pool <= '0;
            raddr      <= '0;
            ren        <= 1'b0;
            busy       <= 1'b0;
            win_valid  <= 1'b0;
            we_pool    <= 1'b0;
            waddr_pool <= '0;
            done       <= 1'b0;
`ifdef POOL_FETCH_TIMEOUT_EN
            wd         <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            k          <= k_d;
            r          <= r_d;
            c          <= c_d;
            p          <= p_d;
            conv_q     <= conv_d;
            wdata_pool <= wdata_d;
            raddr      <= raddr_d;
            ren        <= ren_d;
            busy       <= busy_d;
            win_valid  <= win_valid_d;
            we_pool    <= we_d;
            waddr_pool <= waddr_d;
            done       <= done_d;
`ifdef POOL_FETCH_TIMEOUT_EN
            wd         <= wd_d;
            err        <= err_d;
`endif
        end
    end

    // Next-state, window walk counters and sample capture
    always_comb begin
        state_d = state;
        k_d     = k;
        r_d     = r;
        c_d     = c;
        p_d     = p;
        conv_d  = conv_q;
        wdata_d = wdata_pool;
`ifdef POOL_FETCH_TIMEOUT_EN
        wd_d    = '0;
        err_d   = err;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                    p_d     = '0;
`ifdef POOL_FETCH_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            FETCH: begin
                // rdata answers the read issued on the previous k
                if (k != '0) begin
                    conv_d[2'(k - KW'(1))] = rdata;
                end
                if (k == KW'(4)) begin
                    state_d = WAIT;
                    k_d     = '0;
                end else begin
                    k_d = k + KW'(1);
                end
            end
            WAIT: begin
                if (save_rstl) begin
                    wdata_d = max;
                    state_d = WRITE;
                end
`ifdef POOL_FETCH_TIMEOUT_EN
                // wd counts completed idle WAIT cycles; this is the 255th
                else if (wd == 8'd254) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd + 8'd1;
                end
`endif
            end
            WRITE: begin
                p_d = p + AW'(1);
                k_d = '0;
                if (c_inc == AW'(IMG_W)) begin
                    c_d = '0;
                    if (r_inc == AW'(IMG_W)) begin
                        state_d = DONE;
                    end else begin
                        r_d     = r_inc;
                        state_d = FETCH;
                    end
                end else begin
                    c_d     = c_inc;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the upcoming state, registered by the block above
    always_comb begin
        base        = r_d * AW'(IMG_W) + c_d;
        ren_d       = (state_d == FETCH) && (k_d != KW'(4));
        raddr_d     = '0;
        if (ren_d) begin
            case (k_d[1:0])
                2'd0:    raddr_d = base;
                2'd1:    raddr_d = base + AW'(1);
                2'd2:    raddr_d = base + AW'(IMG_W);
                default: raddr_d = base + AW'(IMG_W) + AW'(1);
            endcase
        end
        busy_d      = (state_d == FETCH) || (state_d == WAIT) || (state_d == WRITE);
        win_valid_d = (state_d == WAIT);
        we_d        = (state_d == WRITE);
        waddr_d     = we_d ? p_d : '0;
        done_d      = (state_d == DONE);
    end

endmodule

// File: tb/tb_pool_window_fetch.sv
// Bench for pool_window_fetch at IMG_W=4 with a 1-cycle-latency RAM model and
// a pooler model that answers two cycles into WAIT with max = rdata_conv3.
module tb_pool_window_fetch;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;

    typedef logic [3:0][DW-1:0] win_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct {
        logic [AW-1:0] a0;
        logic [DW-1:0] e0, e1, e2, e3;
        logic [AW-1:0] ewaddr;
        logic [DW-1:0] ewdata;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, ren, win_valid, we_pool;
    logic [AW-1:0] raddr, waddr_pool;
    logic [DW-1:0] rdata = '0;
    logic [DW-1:0] rdata_conv0, rdata_conv1, rdata_conv2, rdata_conv3;
    logic          save_rstl = 1'b0;
    logic [DW-1:0] max = '0;
    logic [DW-1:0] wdata_pool;
`ifdef POOL_FETCH_TIMEOUT_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    pool_window_fetch #(.addressWidthConv(AW), .dataWidthMax(DW), .IMG_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .raddr(raddr), .ren(ren), .rdata(rdata),
        .rdata_conv0(rdata_conv0), .rdata_conv1(rdata_conv1),
        .rdata_conv2(rdata_conv2), .rdata_conv3(rdata_conv3),
        .win_valid(win_valid), .save_rstl(save_rstl), .max(max),
        .waddr_pool(waddr_pool), .wdata_pool(wdata_pool),
`ifdef POOL_FETCH_TIMEOUT_EN
        .err(err),
`endif
        .we_pool(we_pool)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Conv RAM model
    logic [DW-1:0] mem [16];
    always @(posedge clk) if (ren) rdata <= mem[raddr[3:0]];

    // Pooler model; glitch drives stray save_rstl whenever no window is shown
    int pcnt = 0;
    bit pool_en = 1'b1;
    bit glitch  = 1'b0;
    always @(negedge clk) begin
        if (win_valid && pool_en) begin
            pcnt++;
            if (pcnt == 2) begin
                save_rstl = 1'b1;
                max       = rdata_conv3;
            end else begin
                save_rstl = 1'b0;
            end
        end else begin
            pcnt      = 0;
            save_rstl = glitch && busy;
            if (glitch) max = 8'h55;
        end
    end

    // Monitors: read log, done/write counts, write scoreboard, window checker
    logic [AW-1:0] ren_log[$];
    wr_t           sb[$];
    win_t          wq[$];
    win_t          cur_win = '0;
    bit            wv_prev = 1'b0;
    int            n_done = 0, n_we = 0, n_wv = 0;
    always @(negedge clk) begin
        wr_t e;
        if (ren) ren_log.push_back(raddr);
        if (done) n_done++;
        if (we_pool) begin
            n_we++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {22'd0, waddr_pool}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("sb_waddr", 32'(waddr_pool), 32'(e.addr));
                chk("sb_wdata", 32'(wdata_pool), 32'(e.data));
            end
        end
        if (win_valid) begin
            n_wv++;
            if (!wv_prev) begin
                if (wq.size() == 0) chk("unexpected_window", 32'd1, 32'd0);
                else cur_win = wq.pop_front();
            end
            chk("win_tl", 32'(rdata_conv0), 32'(cur_win[0]));
            chk("win_tr", 32'(rdata_conv1), 32'(cur_win[1]));
            chk("win_bl", 32'(rdata_conv2), 32'(cur_win[2]));
            chk("win_br", 32'(rdata_conv3), 32'(cur_win[3]));
        end
        wv_prev = win_valid;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return win_valid;
            1:       return we_pool;
            default: return done;
        endcase
    endfunction

    task automatic wait_for(input string name, input int sel, input int budget);
        int n = 0;
        while (!sig(sel) && n < budget) begin
            tick();
            n++;
        end
        if (!sig(sel)) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Expected windows (and optionally writes) of one pass from the memory model
    task automatic push_pass(input bit with_writes);
        for (int q = 0; q < 4; q++) begin
            int a0;
            wr_t e;
            a0 = (q / 2) * 2 * W + (q % 2) * 2;
            wq.push_back({mem[a0 + W + 1], mem[a0 + W], mem[a0 + 1], mem[a0]});
            if (with_writes) begin
                e.addr = AW'(q);
                e.data = mem[a0 + W + 1];
                sb.push_back(e);
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_raddr"}, 32'(raddr), 0);
        chk({tag, "_ren"}, 32'(ren), 0);
        chk({tag, "_conv0"}, 32'(rdata_conv0), 0);
        chk({tag, "_conv1"}, 32'(rdata_conv1), 0);
        chk({tag, "_conv2"}, 32'(rdata_conv2), 0);
        chk({tag, "_conv3"}, 32'(rdata_conv3), 0);
        chk({tag, "_win_valid"}, 32'(win_valid), 0);
        chk({tag, "_waddr"}, 32'(waddr_pool), 0);
        chk({tag, "_wdata"}, 32'(wdata_pool), 0);
        chk({tag, "_we"}, 32'(we_pool), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[4];
        int   b_we, b_done, b_wv;
        tbl[0] = '{a0: 0,  e0: 0,  e1: 1,  e2: 4,  e3: 5,  ewaddr: 0, ewdata: 5};
        tbl[1] = '{a0: 2,  e0: 2,  e1: 3,  e2: 6,  e3: 7,  ewaddr: 1, ewdata: 7};
        tbl[2] = '{a0: 8,  e0: 8,  e1: 9,  e2: 12, e3: 13, ewaddr: 2, ewdata: 13};
        tbl[3] = '{a0: 10, e0: 10, e1: 11, e2: 14, e3: 15, ewaddr: 3, ewdata: 15};
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // Pass with mem[i]=i, checked against the table
        ren_log.delete();
        push_pass(1'b1);
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_for("win", 0, 20);
            chk("tbl_conv0", 32'(rdata_conv0), 32'(tbl[i].e0));
            chk("tbl_conv1", 32'(rdata_conv1), 32'(tbl[i].e1));
            chk("tbl_conv2", 32'(rdata_conv2), 32'(tbl[i].e2));
            chk("tbl_conv3", 32'(rdata_conv3), 32'(tbl[i].e3));
            chk("tbl_a0", (ren_log.size() > 4 * i) ? 32'(ren_log[4 * i]) : 32'hFFFF_FFFF, 32'(tbl[i].a0));
            chk("tbl_busy_wait", 32'(busy), 1);
            wait_for("we", 1, 10);
            chk("tbl_waddr", 32'(waddr_pool), 32'(tbl[i].ewaddr));
            chk("tbl_wdata", 32'(wdata_pool), 32'(tbl[i].ewdata));
            chk("tbl_win_valid_in_write", 32'(win_valid), 0);
            tick();
        end
        wait_for("done", 2, 10);
        chk("pass1_busy_at_done", 32'(busy), 0);
        tick();
        chk("pass1_done_one_cycle", 32'(done), 0);
        repeat (2) tick();
        chk("pass1_writes", 32'(n_we), 4);
        chk("pass1_dones", 32'(n_done), 1);
        chk("pass1_reads", 32'(ren_log.size()), 16);
        chk("pass1_sb_empty", 32'(sb.size()), 0);

        // Signed samples pass through untouched; read order 0,1,4,5
        mem[0] = 8'h80; mem[1] = 8'h7F; mem[4] = 8'hFF; mem[5] = 8'h00;
        ren_log.delete();
        push_pass(1'b1);
        b_we = n_we;
        pulse_start();
        wait_for("win_signed", 0, 20);
        chk("signed_conv0", 32'(rdata_conv0), 32'h80);
        chk("signed_conv1", 32'(rdata_conv1), 32'h7F);
        chk("signed_conv2", 32'(rdata_conv2), 32'hFF);
        chk("signed_conv3", 32'(rdata_conv3), 32'h00);
        for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea [4];
            ea = '{10'd0, 10'd1, 10'd4, 10'd5};
            chk("signed_raddr", (ren_log.size() > i) ? 32'(ren_log[i]) : 32'hFFFF_FFFF, 32'(ea[i]));
        end
        wait_for("done_signed", 2, 60);
        repeat (2) tick();
        chk("signed_writes", 32'(n_we - b_we), 4);
        for (int i = 0; i < 16; i++) mem[i] = DW'(i);

        // Stray save_rstl during FETCH and WRITE is ignored
        glitch = 1'b1;
        push_pass(1'b1);
        b_we = n_we;
        pulse_start();
        wait_for("done_glitch", 2, 60);
        glitch = 1'b0;
        repeat (2) tick();
        chk("glitch_writes", 32'(n_we - b_we), 4);
        chk("glitch_sb_empty", 32'(sb.size()), 0);

        // Reset in WAIT of window 2 aborts the pass
        push_pass(1'b1);
        b_we = n_we; b_done = n_done;
        pulse_start();
        wait_for("abort_we0", 1, 20);
        tick();
        wait_for("abort_we1", 1, 20);
        pool_en = 1'b0;
        tick();
        wait_for("abort_win2", 0, 20);
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("abort");
        rst = 1'b0;
        sb.delete();
        wq.delete();
        pool_en = 1'b1;
        repeat (5) tick();
        chk("abort_writes", 32'(n_we - b_we), 2);
        chk("abort_no_done", 32'(n_done - b_done), 0);
        ren_log.delete();
        push_pass(1'b1);
        b_we = n_we;
        pulse_start();
        wait_for("done_restart", 2, 60);
        repeat (2) tick();
        chk("restart_raddr0", (ren_log.size() > 0) ? 32'(ren_log[0]) : 32'hFFFF_FFFF, 0);
        chk("restart_writes", 32'(n_we - b_we), 4);

        // start held high: the next pass begins only after DONE -> IDLE
        push_pass(1'b1);
        push_pass(1'b1);
        b_we = n_we; b_done = n_done;
        start = 1'b1;
        tick();
        wait_for("held_done", 2, 60);
        chk("held_busy_done", 32'(busy), 0);
        tick();
        chk("held_busy_idle", 32'(busy), 0);
        chk("held_ren_idle", 32'(ren), 0);
        tick();
        chk("held_busy_fetch", 32'(busy), 1);
        chk("held_ren_fetch", 32'(ren), 1);
        chk("held_raddr_fetch", 32'(raddr), 0);
        start = 1'b0;
        wait_for("held_done2", 2, 60);
        repeat (2) tick();
        chk("held_dones", 32'(n_done - b_done), 2);
        chk("held_writes", 32'(n_we - b_we), 8);

`ifdef POOL_FETCH_TIMEOUT_EN
        // Pooler silent: watchdog ends the pass after 255 WAIT cycles
        pool_en = 1'b0;
        push_pass(1'b0);
        b_we = n_we; b_done = n_done; b_wv = n_wv;
        pulse_start();
        wait_for("wd_done", 2, 400);
        chk("wd_err", 32'(err), 1);
        tick();
        chk("wd_err_held", 32'(err), 1);
        chk("wd_wait_cycles", 32'(n_wv - b_wv), 255);
        chk("wd_no_write", 32'(n_we - b_we), 0);
        chk("wd_one_done", 32'(n_done - b_done), 1);
        wq.delete();
        pool_en = 1'b1;
        push_pass(1'b1);
        b_we = n_we;
        pulse_start();
        chk("wd_err_cleared", 32'(err), 0);
        wait_for("wd_done2", 2, 60);
        repeat (2) tick();
        chk("wd_recover_writes", 32'(n_we - b_we), 4);
`else
        b_wv = n_wv;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
